lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Upstream command/character sequencer for the `lcd` write stage. It runs the HD44780 power-up initialisation, then renders both players' scores as the fixed text `P1:xx  P2:yy` on line 1. It emits one paced 32-bit word per transfer on `dado` with a one-cycle `clk_en` strobe, so the `lcd` stage only toggles `en` and drives pins. All pacing between words (controller busy times) lives here; `lcd` performs no waiting.

## Interface
Parameters:
- `POWERUP_CYCLES`, default 750_000: idle cycles after reset before the first command (15 ms at 50 MHz).
- `CMD_CYCLES`, default 2_500: gap after every word except clear (50 µs).
- `CLEAR_CYCLES`, default 100_000: gap after the clear command 0x01 (2 ms).

Ports (clock and reset first):
- `clk`  in  1: the only clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `score_p1`  in  7: player 1 score, binary.
- `score_p2`  in  7: player 2 score, binary.
- `score_valid`  in  1: one-cycle request to redraw with the current scores.
- `ready`  out  1: high in IDLE with no pending request.
- `dado`  out  32: word to `lcd`. Bit 8 is rs (0 = command, 1 = data), bits 7:0 are the byte, bits 31:9 are 0.
- `clk_en`  out  1: one-cycle strobe marking a new `dado`.

## Operation
- FSM states: PWRUP → INIT → IDLE ⇄ WRITE. A shared down-counter `gap` implements every wait.
- PWRUP: count `POWERUP_CYCLES`, then enter INIT.
- INIT: emit six commands in this order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each uses gap `CMD_CYCLES`, except 0x01 which uses `CLEAR_CYCLES`. After the last gap, go to IDLE.
- IDLE: a pending request moves the FSM to WRITE and snapshots both scores.
- WRITE: emit 13 words, each followed by a `CMD_CYCLES` gap:
  - command 0x80;
  - data 'P', '1', ':', T1, U1, ' ', ' ', 'P', '2', ':', T2, U2.
  - Tn/Un are the ASCII tens/units digits (0x30 + digit) of the snapshot.
  - After the last gap, return to IDLE.
- Scores above 99 saturate to 99 at snapshot time.
- Request capture:
  - `score_valid` sets a single `pending` flag in any state after reset, including PWRUP and INIT.
  - Only the flag is stored. Scores are sampled on the cycle WRITE is entered, so the latest value always wins.
  - Multiple requests while busy collapse into one redraw.
  - `pending` clears on the cycle WRITE is entered. A `score_valid` on that same cycle sets it again, giving one extra redraw.
- Every emitted word is nonzero, which satisfies the `lcd` trigger condition `dado != 0`.

## Timing
- Reset values: `dado`=0, `clk_en`=0, `ready`=0; state PWRUP, `gap`=`POWERUP_CYCLES`, `pending`=0, word index 0.
- An emission cycle drives `clk_en`=1 with the new `dado` registered on the same edge. `clk_en` is 0 on all other cycles.
- `dado` holds its value until the next emission, because `lcd` consumes it one cycle after the strobe.
- Consecutive strobes are separated by exactly gap+1 cycles. Example: `CMD_CYCLES`=4 puts strobes 5 cycles apart.
- The first INIT strobe occurs `POWERUP_CYCLES`+1 cycles after `rst` deasserts.
- The first WRITE strobe occurs 2 cycles after `score_valid` is sampled in IDLE.
- `ready` is registered. It drops the cycle after `score_valid` and rises the cycle IDLE is re-entered with `pending`=0.
- `rst` mid-sequence aborts immediately and restarts from PWRUP, including the full init. Any pending request is lost.
- `score_valid` during `rst` is ignored.

## Structure
- Package `lcd_pkg` holds:
  - command constants `LCD_FUNC_8BIT`=0x38, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_ENTRY_INC`=0x06, `LCD_LINE1`=0x80;
  - the rs bit index `LCD_RS_BIT`=8;
  - the FSM state enum;
  - the `make_word(rs, byte)` function.
- Sub-module `bin2ascii99`: combinational 7-bit → saturate to 99 → two ASCII bytes. Instantiate it twice, once per player.
- Word selection is a 13-entry case on the index. No ROM.

## Test plan
All scenarios use `POWERUP_CYCLES`=20, `CMD_CYCLES`=4, `CLEAR_CYCLES`=8.
1. Release `rst` → after 21 cycles, strobes carry 0x038, 0x038, 0x038, 0x00C, 0x001, 0x006. Strobes are 5 cycles apart, except 9 cycles after 0x001. `ready` rises after the last gap.
2. In IDLE, `score_p1`=7, `score_p2`=42, pulse `score_valid` → 13 strobes, 5 cycles apart: 0x080, 0x150, 0x131, 0x13A, 0x130, 0x137, 0x120, 0x120, 0x150, 0x132, 0x13A, 0x134, 0x132.
3. `score_p1`=120, `score_p2`=0 → digits are 0x139, 0x139 for player 1 and 0x130, 0x130 for player 2.
4. Three `score_valid` pulses during one WRITE, scores changing to 5/9 before the last pulse → exactly one further redraw, showing 05 and 09.
5. `score_valid` during PWRUP → full init completes, then a redraw starts with no intervening `ready`=1 cycle.
6. Assert `rst` at the 6th WRITE word → next cycle `clk_en`=0, `dado`=0, `ready`=0; the full init repeats with no redraw.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state enum and word builder for the LCD sequencer
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] LCD_FUNC_8BIT = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_LINE1     = 8'h80;

    localparam int LCD_RS_BIT = 8;

    localparam logic [3:0] INIT_WORDS  = 4'd6;
    localparam logic [3:0] WRITE_WORDS = 4'd13;

    typedef enum logic [1:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_WRITE
    } lcd_state_t;

    // rs at bit 8, byte in 7:0, everything above zero
    function automatic logic [31:0] make_word(input logic rs, input logic [7:0] b);
        logic [31:0] w;
        w             = '0;
        w[LCD_RS_BIT] = rs;
        w[7:0]        = b;
        return w;
    endfunction

endpackage

// File: rtl/bin2ascii99.sv
// rtl/bin2ascii99.sv - 7-bit binary to two ASCII decimal digits, saturating at 99
//   i_bin   : binary score
//   o_tens  : ASCII tens digit
//   o_units : ASCII units digit
module bin2ascii99 (
    input  logic [6:0] i_bin,
    output logic [7:0] o_tens,
    output logic [7:0] o_units
);

    logic [6:0] w_sat;
    logic [6:0] w_tens;
    logic [6:0] w_units;

    assign w_sat   = (i_bin > 7'd99) ? 7'd99 : i_bin;
    assign w_tens  = w_sat / 7'd10;
    assign w_units = w_sat % 7'd10;
    assign o_tens  = 8'h30 + {1'b0, w_tens};
    assign o_units = 8'h30 + {1'b0, w_units};

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 init and score-line sequencer feeding the lcd pin stage
//   clk, rst            : clock, synchronous active-high reset
//   score_p1, score_p2  : binary scores
//   score_valid         : one-cycle redraw request
//   ready               : idle with nothing pending
//   dado, clk_en        : paced output word and its one-cycle strobe
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750_000,
    parameter int unsigned CMD_CYCLES     = 2_500,
    parameter int unsigned CLEAR_CYCLES   = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  score_p1,
    input  logic [6:0]  score_p2,
    input  logic        score_valid,
    output logic        ready,
    output logic [31:0] dado,
    output logic        clk_en
);

    localparam logic [31:0] GAP_PWRUP = 32'(POWERUP_CYCLES);
    localparam logic [31:0] GAP_CMD   = 32'(CMD_CYCLES);
    localparam logic [31:0] GAP_CLEAR = 32'(CLEAR_CYCLES);

    lcd_state_t  r_state, w_state_nxt;
    logic [31:0] r_gap, w_gap_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic        r_pending, w_pending_nxt;
    logic        r_ready;
    logic [31:0] r_dado;
    logic        r_clk_en;
    logic [7:0]  r_t1, r_u1, r_t2, r_u2;

    logic [7:0]  w_t1, w_u1, w_t2, w_u2;
    logic        w_emit;
    logic        w_snap;
    logic [31:0] w_word;
    logic [31:0] w_init_word;
    logic [31:0] w_write_word;
    logic [31:0] w_init_gap;

    bin2ascii99 u_p1 (.i_bin(score_p1), .o_tens(w_t1), .o_units(w_u1));
    bin2ascii99 u_p2 (.i_bin(score_p2), .o_tens(w_t2), .o_units(w_u2));

    always_comb begin
        w_init_word = make_word(1'b0, LCD_FUNC_8BIT);
        case (r_idx)
            4'd0, 4'd1, 4'd2: w_init_word = make_word(1'b0, LCD_FUNC_8BIT);
            4'd3:             w_init_word = make_word(1'b0, LCD_DISP_ON);
            4'd4:             w_init_word = make_word(1'b0, LCD_CLEAR);
            4'd5:             w_init_word = make_word(1'b0, LCD_ENTRY_INC);
            default:          w_init_word = make_word(1'b0, LCD_FUNC_8BIT);
        endcase
    end

    // Clear is the only slow command
    assign w_init_gap = (r_idx == 4'd4) ? GAP_CLEAR : GAP_CMD;

    // "P1:tu  P2:tu" from the snapshot taken on WRITE entry
    always_comb begin
        w_write_word = make_word(1'b0, LCD_LINE1);
        case (r_idx)
            4'd0:    w_write_word = make_word(1'b0, LCD_LINE1);
            4'd1:    w_write_word = make_word(1'b1, 8'h50);
            4'd2:    w_write_word = make_word(1'b1, 8'h31);
            4'd3:    w_write_word = make_word(1'b1, 8'h3A);
            4'd4:    w_write_word = make_word(1'b1, r_t1);
            4'd5:    w_write_word = make_word(1'b1, r_u1);
            4'd6:    w_write_word = make_word(1'b1, 8'h20);
            4'd7:    w_write_word = make_word(1'b1, 8'h20);
            4'd8:    w_write_word = make_word(1'b1, 8'h50);
            4'd9:    w_write_word = make_word(1'b1, 8'h32);
            4'd10:   w_write_word = make_word(1'b1, 8'h3A);
            4'd11:   w_write_word = make_word(1'b1, r_t2);
            4'd12:   w_write_word = make_word(1'b1, r_u2);
            default: w_write_word = make_word(1'b0, LCD_LINE1);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        w_emit      = 1'b0;
        w_snap      = 1'b0;
        w_word      = w_init_word;
        case (r_state)
            // The power-up wait expiring emits init word 0 directly, so the
            // first command lands POWERUP_CYCLES+1 cycles after reset release.
            ST_PWRUP: begin
                if (r_gap != 32'd0) begin
                    w_gap_nxt = r_gap - 32'd1;
                end else begin
                    w_emit      = 1'b1;
                    w_gap_nxt   = w_init_gap;
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                if (r_gap != 32'd0) begin
                    w_gap_nxt = r_gap - 32'd1;
                end else if (r_idx == INIT_WORDS) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_emit    = 1'b1;
                    w_gap_nxt = w_init_gap;
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            ST_IDLE: begin
                if (r_pending) begin
                    w_snap      = 1'b1;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_word = w_write_word;
                if (r_gap != 32'd0) begin
                    w_gap_nxt = r_gap - 32'd1;
                end else if (r_idx == WRITE_WORDS) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_emit    = 1'b1;
                    w_gap_nxt = GAP_CMD;
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            default: w_state_nxt = ST_PWRUP;
        endcase
        // A request landing on the snapshot cycle re-arms for one more redraw
        w_pending_nxt = score_valid | (r_pending & ~w_snap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_PWRUP;
            r_gap     <= GAP_PWRUP;
            r_idx     <= 4'd0;
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
            r_dado    <= 32'd0;
            r_clk_en  <= 1'b0;
            r_t1      <= 8'd0;
            r_u1      <= 8'd0;
            r_t2      <= 8'd0;
            r_u2      <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_ready   <= (w_state_nxt == ST_IDLE) && !w_pending_nxt;
            r_clk_en  <= w_emit;
            if (w_emit) begin
                r_dado <= w_word;
            end
            if (w_snap) begin
                r_t1 <= w_t1;
                r_u1 <= w_u1;
                r_t2 <= w_t2;
                r_u2 <= w_u2;
            end
        end
    end

    assign ready  = r_ready;
    assign dado   = r_dado;
    assign clk_en = r_clk_en;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - directed self-checking bench for lcd_sequencer
module tb_lcd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  score_p1 = 7'd0;
    logic [6:0]  score_p2 = 7'd0;
    logic        score_valid = 1'b0;
    logic        ready;
    logic [31:0] dado;
    logic        clk_en;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_hi = 0;
    int last_t = 0;

    lcd_sequencer #(
        .POWERUP_CYCLES(20),
        .CMD_CYCLES    (4),
        .CLEAR_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .score_valid(score_valid),
        .ready      (ready),
        .dado       (dado),
        .clk_en     (clk_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ready === 1'b1) ready_hi <= ready_hi + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, output logic [31:0] d, output int t);
        d = 32'd0;
        t = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (clk_en === 1'b1) begin
                d = dado;
                t = cyc;
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse(input int p1, input int p2);
        score_p1    = 7'(p1);
        score_p2    = 7'(p2);
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic run_init(input int t0, input logic exp_ready);
        logic [31:0] e [6];
        logic [31:0] d;
        int t;
        e = '{32'h038, 32'h038, 32'h038, 32'h00C, 32'h001, 32'h006};
        for (int i = 0; i < 6; i++) begin
            wait_strobe("init", d, t);
            chk($sformatf("init_word%0d", i), d, e[i]);
            if (i == 0) chk("init_first_lat", 32'(t - t0), 32'd21);
            else        chk($sformatf("init_gap%0d", i), 32'(t - last_t), (i == 5) ? 32'd9 : 32'd5);
            last_t = t;
        end
        repeat (4) @(negedge clk);
        chk("init_ready_early", {31'd0, ready}, 32'd0);
        @(negedge clk);
        chk("init_ready_end", {31'd0, ready}, {31'd0, exp_ready});
    endtask

    // digits given by hand per scenario; first_gap 0 skips the lead-in timing check
    task automatic run_redraw(input int t1, input int u1, input int t2, input int u2, input int first_gap);
        logic [31:0] e [13];
        logic [31:0] d;
        int t;
        e = '{32'h080, 32'h150, 32'h131, 32'h13A, 32'h130 + t1, 32'h130 + u1, 32'h120,
              32'h120, 32'h150, 32'h132, 32'h13A, 32'h130 + t2, 32'h130 + u2};
        for (int i = 0; i < 13; i++) begin
            wait_strobe("wr", d, t);
            chk($sformatf("wr_word%0d", i), d, e[i]);
            if (i > 0)               chk($sformatf("wr_gap%0d", i), 32'(t - last_t), 32'd5);
            else if (first_gap != 0) chk("wr_first_lat", 32'(t - last_t), 32'(first_gap));
            last_t = t;
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                chk(tag, 32'd1, 32'd1);
                return;
            end
        end
        chk({tag, "_timeout"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (clk_en !== 1'b0) cnt++;
        end
        chk(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int t0;
        int hi_mark;
        logic [31:0] d;
        int t;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_dado", dado, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);

        // 1: power-up init
        rst = 1'b0;
        t0  = cyc;
        run_init(t0, 1'b1);

        // 2: scores 7 / 42
        chk("idle_ready", {31'd0, ready}, 32'd1);
        last_t = cyc;
        pulse(7, 42);
        chk("ready_drop", {31'd0, ready}, 32'd0);
        run_redraw(0, 7, 4, 2, 3);
        wait_ready("s2_ready");

        // 3: saturation 120 -> 99, zero -> 00
        last_t = cyc;
        pulse(120, 0);
        run_redraw(9, 9, 0, 0, 3);
        wait_ready("s3_ready");

        // 4: three requests during one WRITE collapse into one redraw of 05/09
        pulse(11, 22);
        fork
            run_redraw(1, 1, 2, 2, 0);
            begin
                repeat (8) @(negedge clk);
                pulse(33, 44);
                repeat (10) @(negedge clk);
                pulse(40, 40);
                repeat (10) @(negedge clk);
                pulse(5, 9);
            end
        join
        run_redraw(0, 5, 0, 9, 7);
        wait_ready("s4_ready");
        expect_quiet("s4_no_third", 40);

        // 5: request during PWRUP, redraw follows init with no ready pulse
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        t0      = cyc;
        hi_mark = ready_hi;
        fork
            run_init(t0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                pulse(3, 8);
            end
        join
        run_redraw(0, 3, 0, 8, 7);
        chk("s5_no_ready", 32'(ready_hi - hi_mark), 32'd0);
        wait_ready("s5_ready");

        // 6: reset at the 6th WRITE word drops the pending redraw
        pulse(50, 60);
        for (int i = 0; i < 6; i++) begin
            wait_strobe("s6", d, t);
            if (i == 2) pulse(50, 60);
        end
        chk("s6_word6", d, 32'h130);
        rst         = 1'b1;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        chk("s6_clk_en", {31'd0, clk_en}, 32'd0);
        chk("s6_dado", dado, 32'd0);
        chk("s6_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        run_init(t0, 1'b1);
        expect_quiet("s6_no_redraw", 40);
        chk("s6_idle_ready", {31'd0, ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
